pc_fetch_unit: RTL and testbench
================================

// Module: pc_fetch_unit
// PURPOSE
//  Consumer end of the next-PC interface: holds the architectural PC, fetches the
//  instruction at PC from instruction memory over a req/gnt/rvalid handshake, and
//  presents it to decode. It latches the npc value computed by the next-PC logic
//  when the core commits the current instruction, then starts the next fetch.
//  Sits between the next-PC logic and IM, at the front of the MIPS core.
// PARAMETERS
//  RESET_PC   32'h0000_3000  PC value loaded on reset
//  CNT_W      32             width of the retired-instruction counter
// PORTS
//  clk          in   1      core clock, rising edge
//  rst_n        in   1      asynchronous, active-low reset
//  npc          in   32     next PC from the next-PC logic, sampled on commit
//  commit       in   1      core retires the current instr; qualified by instr_valid
//  imem_req     out  1      fetch request to IM
//  imem_addr    out  32     fetch byte address (= pc)
//  imem_gnt     in   1      IM accepts the request (may come in the same cycle as req)
//  imem_rvalid  in   1      IM read data valid
//  imem_rdata   in   32     IM read data
//  pc           out  32     current PC, fed to the next-PC logic and as the jal link source
//  instr        out  32     fetched instruction, held stable while instr_valid=1
//  instr_valid  out  1      instr corresponds to pc
//  addr_err     out  1      sticky: commit supplied an npc with npc[1:0]!=0
//  retire_cnt   out  CNT_W  count of accepted commits
// BEHAVIOUR
//  Reset (async assert, sync release): pc=RESET_PC, instr=0, instr_valid=0,
//   imem_req=0, addr_err=0, retire_cnt=0, state=BOOT.
//  FSM:
//   BOOT   - imem_req=0. Next cycle -> FETCH.
//   FETCH  - imem_req=1, imem_addr=pc. req/addr are held stable until imem_gnt.
//            On gnt -> WAIT.
//   WAIT   - imem_req=0. On imem_rvalid: instr<=imem_rdata -> VALID.
//   VALID  - instr_valid=1.
//            On commit with npc[1:0]==0: pc<=npc, retire_cnt++, -> FETCH.
//            On commit with npc[1:0]!=0: pc unchanged, addr_err<=1, -> ERR.
//   ERR    - imem_req=0, instr_valid=0. Held until reset.
//  Handshake and ordering:
//   - At most one outstanding fetch.
//   - imem_rvalid is accepted only in WAIT. In any other state it is ignored,
//     including stray responses after a mid-fetch reset.
//   - imem_rvalid can arrive no earlier than the cycle after gnt.
//  Latency:
//   - commit in cycle t -> new pc and imem_req=1 in t+1.
//   - Zero-wait IM (gnt in t+1, rvalid in t+2) -> instr_valid in t+3.
//  commit outside VALID is ignored: no pc update, no count.
//  npc is used as-is (32 bits, no arithmetic here).
//  retire_cnt wraps modulo 2^CNT_W with no flag.
//  instr_valid drops in the cycle after an accepted commit.
//  Reset asserted in any state aborts the fetch; state returns to BOOT.
// STRUCTURE
//  Shared package mips_pkg: RESET_PC default, fetch_state_t
//   (BOOT, FETCH, WAIT, VALID, ERR).
//  One natural sub-module: pc_reg. It is the resettable 32-bit PC register with a
//   load enable; everything else stays in the top.
// TESTING
//  1. rst_n=0 mid-run -> pc=0x0000_3000, imem_req=0, instr_valid=0, retire_cnt=0
//     immediately. Release -> BOOT, then imem_req=1, imem_addr=0x0000_3000.
//  2. gnt in the req cycle, rvalid next with rdata=0x2408_0005 -> instr_valid=1 and
//     instr=0x2408_0005. commit with npc=0x0000_3004 -> pc=0x0000_3004 and
//     retire_cnt=1 next cycle.
//  3. gnt held low for 3 cycles -> imem_req=1, addr stable for 4 cycles. rvalid
//     pulsed while in FETCH -> ignored, instr unchanged.
//  4. commit with npc=0x0000_3006 -> addr_err=1, pc stays 0x0000_3000, imem_req=0
//     for the following 10 cycles.
//  5. commit while instr_valid=0 (in WAIT) -> pc and retire_cnt unchanged.
//     Reset between gnt and rvalid, late rvalid after release -> ignored; the
//     fetch restarts at RESET_PC.
//  6. With CNT_W=4, 16 back-to-back jumps (npc=0x0000_3000) -> retire_cnt wraps to
//     0, addr_err stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared MIPS front-end constants and fetch FSM state type
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;

    typedef enum logic [2:0] {
        BOOT  = 3'd0,
        FETCH = 3'd1,
        WAIT  = 3'd2,
        VALID = 3'd3,
        ERR   = 3'd4
    } fetch_state_t;

endpackage

// File: rtl/pc_reg.sv
// rtl/pc_reg.sv - resettable 32-bit program counter register with load enable
// Ports:
//   clk   in  1   core clock, rising edge
//   rst_n in  1   asynchronous active-low reset, loads RESET_PC
//   load  in  1   capture d on the next rising edge
//   d     in  32  next PC value
//   q     out 32  current PC
module pc_reg
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [31:0] d,
    output logic [31:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_PC;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// rtl/pc_fetch_unit.sv - architectural PC holder and single-outstanding instruction fetcher
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   npc, commit                     next PC and retire strobe from the core
//   imem_req, imem_addr             fetch request and byte address (= pc)
//   imem_gnt, imem_rvalid, imem_rdata  IM accept, read valid and read data
//   pc, instr, instr_valid          current PC and fetched instruction to decode
//   addr_err                        sticky misaligned-npc flag
//   retire_cnt                      count of accepted commits, wraps silently
module pc_fetch_unit
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int          CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      npc,
    input  logic             commit,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      pc,
    output logic [31:0]      instr,
    output logic             instr_valid,
    output logic             addr_err,
    output logic [CNT_W-1:0] retire_cnt
);

    fetch_state_t state;
    fetch_state_t state_nxt;
    logic         commit_ok;
    logic         commit_bad;
    logic         rsp_take;

    // A commit only means something while decode holds a valid instruction.
    assign commit_ok  = (state == VALID) && commit && (npc[1:0] == 2'b00);
    assign commit_bad = (state == VALID) && commit && (npc[1:0] != 2'b00);
    // Responses outside WAIT (e.g. stale ones after a reset) are dropped.
    assign rsp_take   = (state == WAIT) && imem_rvalid;

    assign imem_req    = (state == FETCH);
    assign imem_addr   = pc;
    assign instr_valid = (state == VALID);

    pc_reg #(
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (commit_ok),
        .d     (npc),
        .q     (pc)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            BOOT:    state_nxt = FETCH;
            FETCH:   if (imem_gnt) state_nxt = WAIT;
            WAIT:    if (imem_rvalid) state_nxt = VALID;
            VALID: begin
                if (commit_ok) begin
                    state_nxt = FETCH;
                end else if (commit_bad) begin
                    state_nxt = ERR;
                end
            end
            ERR:     state_nxt = ERR;
            default: state_nxt = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= BOOT;
            instr      <= 32'h0;
            addr_err   <= 1'b0;
            retire_cnt <= '0;
        end else begin
            state <= state_nxt;
            if (rsp_take) begin
                instr <= imem_rdata;
            end
            if (commit_bad) begin
                addr_err <= 1'b1;
            end
            if (commit_ok) begin
                retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: tb/tb_pc_fetch_unit.sv
// tb/tb_pc_fetch_unit.sv - scoreboard bench for pc_fetch_unit
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] npc;
    logic        commit;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic        instr_valid;
    logic        addr_err;
    logic [3:0]  retire_cnt;

    int checks   = 0;
    int failures = 0;

    logic [31:0] exp_addr_q[$];
    logic [31:0] exp_instr_q[$];
    logic        iv_q = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit #(
        .RESET_PC (32'h0000_3000),
        .CNT_W    (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .npc         (npc),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .pc          (pc),
        .instr       (instr),
        .instr_valid (instr_valid),
        .addr_err    (addr_err),
        .retire_cnt  (retire_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: pops the expected fetch address on every accepted request and
    // the expected instruction on every rising edge of instr_valid.
    always @(negedge clk) begin
        if (!rst_n) begin
            iv_q = 1'b0;
        end else begin
            if (imem_req && imem_gnt) begin
                if (exp_addr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_addr: unexpected request addr %h", imem_addr);
                end else begin
                    chk("fetch_addr", imem_addr, exp_addr_q.pop_front());
                end
            end
            if (instr_valid && !iv_q) begin
                if (exp_instr_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL fetch_instr: unexpected valid instr %h", instr);
                end else begin
                    chk("fetch_instr", instr, exp_instr_q.pop_front());
                end
            end
            iv_q = instr_valid;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n       = 1'b0;
        npc         = 32'h0;
        commit      = 1'b0;
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
        repeat (2) tick();

        chk("rst_pc", pc, 32'h0000_3000);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk("rst_iv", {31'h0, instr_valid}, 32'h0);
        chk("rst_cnt", {28'h0, retire_cnt}, 32'h0);
        chk("rst_err", {31'h0, addr_err}, 32'h0);
        chk("rst_instr", instr, 32'h0);

        rst_n = 1'b1;
        chk("boot_req", {31'h0, imem_req}, 32'h0);
        tick();
        chk("fetch_req", {31'h0, imem_req}, 32'h1);
        chk("fetch_addr0", imem_addr, 32'h0000_3000);

        // Grant in the request cycle, data the cycle after.
        exp_addr_q.push_back(32'h0000_3000);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        chk("wait_req", {31'h0, imem_req}, 32'h0);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h2408_0005;
        exp_instr_q.push_back(32'h2408_0005);
        tick();
        imem_rvalid = 1'b0;
        chk("valid_iv", {31'h0, instr_valid}, 32'h1);
        chk("valid_instr", instr, 32'h2408_0005);
        commit = 1'b1;
        npc    = 32'h0000_3004;
        tick();
        commit = 1'b0;
        chk("commit_pc", pc, 32'h0000_3004);
        chk("commit_cnt", {28'h0, retire_cnt}, 32'h1);
        chk("commit_iv_drop", {31'h0, instr_valid}, 32'h0);
        chk("commit_req", {31'h0, imem_req}, 32'h1);

        // Grant withheld for 3 cycles, with a stray rvalid while in FETCH.
        for (int i = 0; i < 3; i++) begin
            imem_rvalid = (i == 1);
            imem_rdata  = 32'hDEAD_BEEF;
            tick();
            chk("stall_req", {31'h0, imem_req}, 32'h1);
            chk("stall_addr", imem_addr, 32'h0000_3004);
        end
        imem_rvalid = 1'b0;
        chk("stray_instr", instr, 32'h2408_0005);
        chk("stray_iv", {31'h0, instr_valid}, 32'h0);
        exp_addr_q.push_back(32'h0000_3004);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;

        // Commit while waiting for data is ignored.
        commit = 1'b1;
        npc    = 32'h0000_4000;
        tick();
        commit = 1'b0;
        chk("wait_commit_pc", pc, 32'h0000_3004);
        chk("wait_commit_cnt", {28'h0, retire_cnt}, 32'h1);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h8C09_0000;
        exp_instr_q.push_back(32'h8C09_0000);
        tick();
        imem_rvalid = 1'b0;
        chk("valid2_iv", {31'h0, instr_valid}, 32'h1);

        // Misaligned npc: sticky error, fetch halts.
        commit = 1'b1;
        npc    = 32'h0000_3006;
        tick();
        npc = 32'h0000_3008;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("err_flag", {31'h0, addr_err}, 32'h1);
            chk("err_req", {31'h0, imem_req}, 32'h0);
            chk("err_iv", {31'h0, instr_valid}, 32'h0);
            chk("err_pc", pc, 32'h0000_3004);
        end
        commit = 1'b0;
        chk("err_cnt", {28'h0, retire_cnt}, 32'h1);

        // Asynchronous reset mid-run takes effect without a clock edge.
        rst_n = 1'b0;
        #1;
        chk("arst_pc", pc, 32'h0000_3000);
        chk("arst_req", {31'h0, imem_req}, 32'h0);
        chk("arst_iv", {31'h0, instr_valid}, 32'h0);
        chk("arst_cnt", {28'h0, retire_cnt}, 32'h0);
        chk("arst_err", {31'h0, addr_err}, 32'h0);
        rst_n = 1'b1;
        tick();
        chk("refetch_req", {31'h0, imem_req}, 32'h1);
        chk("refetch_addr", imem_addr, 32'h0000_3000);

        // Reset between grant and data; the late response must be dropped.
        exp_addr_q.push_back(32'h0000_3000);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_BAD0;
        tick();
        imem_rvalid = 1'b0;
        chk("late_instr", instr, 32'h0);
        chk("late_iv", {31'h0, instr_valid}, 32'h0);
        chk("late_req", {31'h0, imem_req}, 32'h1);
        chk("late_addr", imem_addr, 32'h0000_3000);
        exp_addr_q.push_back(32'h0000_3000);
        imem_gnt = 1'b1;
        tick();
        imem_gnt = 1'b0;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0800_0C00;
        exp_instr_q.push_back(32'h0800_0C00);
        tick();
        imem_rvalid = 1'b0;

        // 16 back-to-back jumps to 0x3000: 4-bit counter wraps to 0.
        for (int i = 0; i < 16; i++) begin
            commit = 1'b1;
            npc    = 32'h0000_3000;
            tick();
            commit = 1'b0;
            chk("loop_iv_drop", {31'h0, instr_valid}, 32'h0);
            if (i == 14) chk("loop_cnt15", {28'h0, retire_cnt}, 32'hF);
            exp_addr_q.push_back(32'h0000_3000);
            imem_gnt = 1'b1;
            tick();
            imem_gnt = 1'b0;
            imem_rvalid = 1'b1;
            imem_rdata  = 32'h1000_0000 + i;
            exp_instr_q.push_back(32'h1000_0000 + i);
            tick();
            imem_rvalid = 1'b0;
        end
        chk("wrap_cnt", {28'h0, retire_cnt}, 32'h0);
        chk("wrap_err", {31'h0, addr_err}, 32'h0);
        chk("wrap_pc", pc, 32'h0000_3000);

        tick();
        chk("sb_addr_drain", exp_addr_q.size(), 32'h0);
        chk("sb_instr_drain", exp_instr_q.size(), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
